// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: frame geometry defaults,
// the 12-bit RGB444 pixel layout and the capture FSM state encoding.
package cam_pkg;

    localparam int IMAGE_WIDTH_DEF  = 320;
    localparam int IMAGE_HEIGHT_DEF = 240;

    // Width of a raster address covering one full frame.
    function automatic int addr_bits(input int width, input int height);
        return $clog2(width * height);
    endfunction

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic [2:0] {
        WAIT_VSYNC,
        FRAME_IDLE,
        BYTE_LO,
        BYTE_HI,
        LINE_END
    } cap_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector. The history register resets high so a
// signal that is already asserted when reset releases does not count as an edge.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Remember the previous sample of the input.
    always_ff @(posedge clk) begin
        if (!reset_n) sig_q <= 1'b1;
        else          sig_q <= sig;
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/ov7670_capture_writer.sv
// Assembles OV7670 RGB444 byte pairs into 12-bit pixels and writes them to
// the frame BRAM in raster order. Reports frame completion and whether the
// frame that just closed had the expected geometry.
module ov7670_capture_writer
    import cam_pkg::*;
#(
    parameter int IMAGE_WIDTH  = IMAGE_WIDTH_DEF,
    parameter int IMAGE_HEIGHT = IMAGE_HEIGHT_DEF,
    parameter int ADDR_BITS    = addr_bits(IMAGE_WIDTH, IMAGE_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vsync,
    input  logic                 href,
    input  logic [7:0]           d,
    output logic [ADDR_BITS-1:0] wraddress,
    output logic [11:0]          wrdata,
    output logic                 wren,
    output logic                 frame_done,
    output logic                 frame_error
);

    // Counters have one spare code above the nominal size so overruns
    // saturate instead of wrapping back into the valid range.
    localparam int COL_BITS = $clog2(IMAGE_WIDTH + 2);
    localparam int ROW_BITS = $clog2(IMAGE_HEIGHT + 2);
    localparam logic [COL_BITS-1:0] COL_FULL = COL_BITS'(IMAGE_WIDTH);
    localparam logic [COL_BITS-1:0] COL_SAT  = COL_BITS'(IMAGE_WIDTH + 1);
    localparam logic [ROW_BITS-1:0] ROW_FULL = ROW_BITS'(IMAGE_HEIGHT);
    localparam logic [ROW_BITS-1:0] ROW_SAT  = ROW_BITS'(IMAGE_HEIGHT + 1);

    cap_state_t            state, state_next;
    logic                  vsync_rise;
    logic                  line_byte;
    logic                  take_hi, take_lo, close;
    logic                  in_bounds;
    logic [3:0]            hi_nib;
    logic [COL_BITS-1:0]   col;
    logic [ROW_BITS-1:0]   row;
    logic [ADDR_BITS-1:0]  pix_idx;
    logic                  err;
    logic                  odd_end;
    pixel_t                px;

    edge_detect u_vsync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (vsync),
        .rise    (vsync_rise)
    );

    // href is meaningless while vsync is high.
    assign line_byte = href & ~vsync;
    assign in_bounds = (col < COL_FULL) && (row < ROW_FULL);
    assign px        = '{r: hi_nib, g: d[7:4], b: d[3:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= WAIT_VSYNC;
        else          state <= state_next;
    end

    // Next state and byte strobes; a vsync rise overrides any line activity.
    always_comb begin
        state_next = state;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        close      = 1'b0;
        if (vsync_rise) begin
            close      = (state != WAIT_VSYNC);
            state_next = FRAME_IDLE;
        end else begin
            case (state)
                WAIT_VSYNC: state_next = WAIT_VSYNC;
                FRAME_IDLE: begin
                    if (line_byte) begin
                        take_hi    = 1'b1;
                        state_next = BYTE_LO;
                    end
                end
                BYTE_LO: begin
                    if (line_byte) begin
                        take_lo    = 1'b1;
                        state_next = BYTE_HI;
                    end else begin
                        state_next = LINE_END;
                    end
                end
                BYTE_HI: begin
                    if (line_byte) begin
                        take_hi    = 1'b1;
                        state_next = BYTE_LO;
                    end else begin
                        state_next = LINE_END;
                    end
                end
                LINE_END:   state_next = FRAME_IDLE;
                default:    state_next = WAIT_VSYNC;
            endcase
        end
    end

    // Pixel assembly, BRAM write port, geometry counters and frame status.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wraddress   <= '0;
            wrdata      <= '0;
            wren        <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            hi_nib      <= '0;
            col         <= '0;
            row         <= '0;
            pix_idx     <= '0;
            err         <= 1'b0;
            odd_end     <= 1'b0;
        end else begin
            wren       <= 1'b0;
            frame_done <= 1'b0;
            if (vsync_rise) begin
                if (close) begin
                    frame_done  <= 1'b1;
                    frame_error <= err | (row != ROW_FULL);
                end
                col     <= '0;
                row     <= '0;
                pix_idx <= '0;
                err     <= 1'b0;
                odd_end <= 1'b0;
            end else begin
                if (take_hi) hi_nib <= d[3:0];
                if (take_lo) begin
                    if (in_bounds) begin
                        wren      <= 1'b1;
                        wrdata    <= px;
                        wraddress <= pix_idx;
                        pix_idx   <= pix_idx + ADDR_BITS'(1);
                    end else begin
                        err <= 1'b1;
                    end
                    if (col != COL_SAT) col <= col + COL_BITS'(1);
                end
                if (state_next == LINE_END) odd_end <= (state == BYTE_LO);
                if (state == LINE_END) begin
                    if ((col != COL_FULL) || odd_end) err <= 1'b1;
                    col <= '0;
                    if (row != ROW_SAT) row <= row + ROW_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_writer.sv
// Bench for ov7670_capture_writer on a reduced 8x4 frame. A line-level model
// derives every expected write, frame_done pulse and frame_error value from
// the byte counts of each line; a compare process checks the DUT every cycle.
module tb_ov7670_capture_writer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AB = 5;

    typedef struct packed {
        logic [AB-1:0] a;
        logic [11:0]   v;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n, vsync, href;
    logic [7:0]    d;
    logic [AB-1:0] wraddress;
    logic [11:0]   wrdata;
    logic          wren, frame_done, frame_error;

    ov7670_capture_writer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ADDR_BITS    (AB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vsync       (vsync),
        .href        (href),
        .d           (d),
        .wraddress   (wraddress),
        .wrdata      (wrdata),
        .wren        (wren),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;

    // Model state
    wr_t  exp_q[$];
    bit   m_armed = 0;
    int   m_row = 0;
    int   m_idx = 0;
    bit   m_err = 0;
    bit   wr_now = 0, done_now = 0, rst_now = 0, ferr_next = 0;
    bit   exp_wren_q = 0, exp_done_q = 0, exp_rst_q = 0, exp_ferr_q = 0;

    // Observed DUT activity
    logic [11:0] mem [0:(1<<AB)-1];
    int   wr_count = 0;
    int   done_count = 0;
    int   last_addr = -1;
    int   first_addr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] pat(input int mode, input int r, input int c, input bit lo);
        logic [7:0] res;
        case (mode)
            0:       res = lo ? 8'h5C : 8'h0A;
            1:       res = lo ? 8'h3C : {4'h9, c[3:0]};
            default: res = lo ? {c[3:0], 4'h5} : {4'h6, r[3:0]};
        endcase
        return res;
    endfunction

    // Advance the expected control outputs in lockstep with the DUT.
    always @(posedge clk) begin
        exp_wren_q <= wr_now;
        exp_done_q <= done_now;
        exp_rst_q  <= rst_now;
        if (rst_now)       exp_ferr_q <= 1'b0;
        else if (done_now) exp_ferr_q <= ferr_next;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("wren", {31'd0, wren}, {31'd0, exp_wren_q});
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done_q});
        chk("frame_error", {31'd0, frame_error}, {31'd0, exp_ferr_q});
        if (exp_rst_q) begin
            chk("rst_wraddress", 32'(wraddress), 32'd0);
            chk("rst_wrdata", 32'(wrdata), 32'd0);
        end
        if (frame_done === 1'b1) done_count++;
        if (wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wraddress, wrdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wraddress", 32'(wraddress), 32'(e.a));
                chk("wrdata", 32'(wrdata), 32'(e.v));
            end
            if (wr_count == 0) first_addr = int'(wraddress);
            mem[wraddress] = wrdata;
            last_addr = int'(wraddress);
            wr_count++;
        end
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] dat,
                       input logic rn, input bit wr, input bit done);
        vsync = v; href = h; d = dat; reset_n = rn;
        wr_now = wr; done_now = done; rst_now = !rn;
        @(posedge clk);
        #1;
    endtask

    // One line of nbytes bytes; rst_at >= 0 pulls reset_n low on that byte.
    task automatic send_line(input int nbytes, input int mode, input int r, input int rst_at);
        for (int b = 0; b < nbytes; b++) begin
            int c;
            logic [7:0] hi, dat;
            bit wr, rst;
            c   = b / 2;
            hi  = pat(mode, r, c, 1'b0);
            dat = (b % 2 == 1) ? pat(mode, r, c, 1'b1) : hi;
            wr  = 0;
            rst = (b == rst_at);
            if (rst) begin
                m_armed = 0;
            end else if (m_armed && (b % 2 == 1)) begin
                if (m_row < H && c < W) begin
                    exp_q.push_back(wr_t'{a: AB'(m_idx), v: {hi[3:0], dat}});
                    m_idx++;
                    wr = 1;
                end else begin
                    m_err = 1;
                end
            end
            cyc(1'b0, 1'b1, dat, !rst, wr, 1'b0);
        end
        if (m_armed) begin
            if ((nbytes % 2 == 1) || (nbytes / 2 != W)) m_err = 1;
            m_row++;
        end
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic vsync_pulse(input bit with_href);
        bit done;
        done = m_armed;
        ferr_next = m_err || (m_row != H);
        cyc(1'b1, with_href, 8'hAA, 1'b1, 1'b0, done);
        m_armed = 1; m_row = 0; m_idx = 0; m_err = 0;
        cyc(1'b1, with_href, 8'h55, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int mode, input int l0, input int l1, input int l2, input int l3);
        wr_count = 0;
        send_line(l0, mode, 0, -1);
        send_line(l1, mode, 1, -1);
        send_line(l2, mode, 2, -1);
        send_line(l3, mode, 3, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        vsync = 0; href = 0; d = 0; reset_n = 0;
        repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("reset_wren", {31'd0, wren}, 32'd0);
        chk("reset_frame_error", {31'd0, frame_error}, 32'd0);
        chk("reset_wraddress", 32'(wraddress), 32'd0);

        // Data before the first vsync is discarded
        send_frame(0, 16, 16, 0, 0);
        chk("startup_writes", 32'(wr_count), 32'd0);
        chk("startup_done", 32'(done_count), 32'd0);
        vsync_pulse(0);
        chk("arm_no_done", 32'(done_count), 32'd0);

        // Clean frame
        send_frame(0, 16, 16, 16, 16);
        vsync_pulse(0);
        chk("clean_writes", 32'(wr_count), 32'd32);
        chk("clean_last_addr", 32'(last_addr), 32'd31);
        chk("clean_last_data", 32'(mem[31]), 32'hA5C);
        chk("clean_done_count", 32'(done_count), 32'd1);
        chk("clean_frame_error", {31'd0, frame_error}, 32'd0);

        // Address ordering, upper nibble of high byte ignored; vsync with href closes
        send_frame(1, 16, 16, 16, 16);
        vsync_pulse(1);
        chk("order_first_addr", 32'(first_addr), 32'd0);
        chk("order_line1_start", 32'(mem[8]), 32'h03C);
        chk("order_line1_col1", 32'(mem[9]), 32'h13C);
        chk("order_line1_end", 32'(mem[15]), 32'h73C);
        chk("order_frame_error", {31'd0, frame_error}, 32'd0);

        // Short line shifts later lines
        send_frame(2, 16, 14, 16, 16);
        vsync_pulse(0);
        chk("short_writes", 32'(wr_count), 32'd31);
        chk("short_row2_start", 32'(mem[15]), 32'h205);
        chk("short_last", 32'(mem[30]), 32'h375);
        chk("short_frame_error", {31'd0, frame_error}, 32'd1);

        send_frame(0, 16, 16, 16, 16);
        vsync_pulse(0);
        chk("recover_frame_error", {31'd0, frame_error}, 32'd0);

        // Odd byte count
        send_frame(2, 16, 17, 16, 16);
        vsync_pulse(0);
        chk("odd_writes", 32'(wr_count), 32'd32);
        chk("odd_frame_error", {31'd0, frame_error}, 32'd1);

        send_frame(0, 16, 16, 16, 16);
        vsync_pulse(0);
        chk("clean2_frame_error", {31'd0, frame_error}, 32'd0);

        // Overrun: ninth pixel of line 2 is not written
        send_frame(2, 16, 16, 18, 16);
        vsync_pulse(0);
        chk("overrun_writes", 32'(wr_count), 32'd32);
        chk("overrun_row3_start", 32'(mem[24]), 32'h305);
        chk("overrun_frame_error", {31'd0, frame_error}, 32'd1);

        // Mid-frame reset
        dc = done_count;
        send_line(16, 0, 0, -1);
        wr_count = 0;
        send_line(16, 0, 1, 7);
        chk("rst_partial_writes", 32'(wr_count), 32'd3);
        chk("rst_cleared_error", {31'd0, frame_error}, 32'd0);
        send_line(16, 0, 2, -1);
        send_line(16, 0, 3, -1);
        chk("rst_no_more_writes", 32'(wr_count), 32'd3);
        vsync_pulse(0);
        chk("rst_no_done", 32'(done_count), 32'(dc));
        send_frame(2, 16, 16, 16, 16);
        vsync_pulse(0);
        chk("post_rst_first_addr", 32'(first_addr), 32'd0);
        chk("post_rst_first_data", 32'(mem[0]), 32'h005);
        chk("post_rst_writes", 32'(wr_count), 32'd32);
        chk("post_rst_done", 32'(done_count), 32'(dc + 1));
        chk("post_rst_frame_error", {31'd0, frame_error}, 32'd0);

        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_writer.md
Name: ov7670_capture_writer

Overview:
- Write side of the frame BRAM that the red-pixel direction detector reads.
- Takes the OV7670 RGB444 byte stream (vsync/href/data) and assembles 12-bit pixels laid out as R[11:8], G[7:4], B[3:0].
- Writes each pixel to BRAM at a raster-order address: row*IMAGE_WIDTH + col.
- Flags frame completion and framing errors so downstream consumers know when a frame is clean.

Parameters:
- IMAGE_WIDTH, 320, pixels per line delivered by the camera (QVGA).
- IMAGE_HEIGHT, 240, lines per frame.
- ADDR_BITS, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), BRAM write address width.

Ports:
- clk  in  1  camera pixel clock (pclk); the only clock of the block.
- reset_n  in  1  synchronous, active-low reset.
- vsync  in  1  camera frame sync; high between frames.
- href  in  1  camera line valid; data bytes are valid while high.
- d  in  8  camera data byte.
- wraddress  out  ADDR_BITS  BRAM write address.
- wrdata  out  12  pixel {R,G,B} to BRAM.
- wren  out  1  BRAM write enable, one cycle per pixel.
- frame_done  out  1  one-cycle pulse when a frame closes.
- frame_error  out  1  status of the last closed frame; 1 means it was malformed.

Behaviour:
- Clock and reset:
  - Clock is clk; reset is synchronous and active-low on reset_n.
  - All inputs are sampled on the rising edge of clk.
- Reset values: wraddress=0, wrdata=0, wren=0, frame_done=0, frame_error=0, FSM=WAIT_VSYNC, counters=0.
- FSM states:
  - WAIT_VSYNC: entered after reset. Discards all data until the first vsync rising edge, so a partial frame is never written. On vsync rise, go to FRAME_IDLE with row=0, col=0.
  - FRAME_IDLE: between lines. When href=1, sample d as the high byte and go to BYTE_LO.
  - BYTE_LO: when href=1, build the pixel as {hi[3:0], d}, then go to BYTE_HI. When href=0, go to LINE_END.
  - BYTE_HI: when href=1, sample d as the high byte and go to BYTE_LO. When href=0, go to LINE_END.
  - LINE_END: a single cycle. Performs the line checks, row++, col=0, then returns to FRAME_IDLE.
- Byte format: high byte is xxxxRRRR, so only the low nibble is kept. Low byte is GGGGBBBB.
- Write timing (latency 1 cycle):
  - wren is asserted in the cycle after the low byte is sampled.
  - In that cycle, wrdata and wraddress are both valid.
  - wraddress comes from a running pixel index (reset to 0 at frame start, +1 after each write). No multiply is used.
- Bounds checks:
  - A write is suppressed if col >= IMAGE_WIDTH or row >= IMAGE_HEIGHT. The error flag is set instead.
  - This guarantees wraddress never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-1.
- Line checks in LINE_END: set the error flag if col != IMAGE_WIDTH, or if the line ended after an odd byte (the state before LINE_END was BYTE_LO). A dangling high byte is discarded.
- Frame close, on a vsync rising edge in any state other than WAIT_VSYNC:
  - frame_done pulses for exactly one cycle.
  - frame_error is updated to (error flag OR row != IMAGE_HEIGHT).
  - Counters, pixel index and error flag are cleared, and the FSM goes to FRAME_IDLE.
  - frame_error holds its value until the next frame close.
- Precedence and corner cases:
  - A vsync rise beats an href event in the same cycle: the frame closes and the byte is dropped.
  - href high while vsync is high is ignored.
  - Mid-frame reset: outputs go to reset values the next cycle, the FSM returns to WAIT_VSYNC, and the remainder of the current frame is never written.
- Ordering and overlap with the reader:
  - The last pixel of a frame is always written before the frame_done pulse.
  - Writing address 0 of frame N+1 may overlap the reader's address-0 cycle. This is accepted, because the reader latches its result on address 0.

Decomposition:
- Shared package cam_pkg holds:
  - the IMAGE_WIDTH/IMAGE_HEIGHT defaults and the ADDR_BITS function;
  - typedef pixel_t (12-bit packed struct with fields r, g, b);
  - the capture FSM state enum.
- One natural sub-module: edge_detect, a registered rising-edge detector used for vsync.

Test Plan:
- Clean frame: reset, vsync pulse, 240 lines of 640 bytes with byte pair (0x0A, 0x5C), then vsync → 76800 writes with wrdata=0xA5C, last wraddress=76799, frame_done pulses once, frame_error=0.
- Address ordering: pixel value = column (R=col[3:0]) for 2 lines → line 1 starts at wraddress=320, wren is one cycle after each low byte, there are no gaps in addresses.
- Short line: line 5 has 638 bytes → remaining lines land at shifted addresses, frame_error=1 at frame close, and the next clean frame gives frame_error=0.
- Odd byte and overrun: line of 641 bytes → dangling byte dropped and flag set. Line of 642 bytes → the 321st pixel is not written (no wren), frame_error=1.
- Startup: data before the first vsync after reset → no wren, no frame_done, until the vsync rising edge.
- Mid-frame reset: reset_n low at pixel 1000 → all outputs 0 the next cycle, no writes until the next vsync, then a clean frame is captured from address 0.
